// File: rtl/ootx_frame_decoder.sv
// OOTX frame decoder: rebuilds a Lighthouse OOTX frame from one-bit-per-sync strobes,
// streams the payload bytes and validates the trailing little-endian CRC32.
module ootx_frame_decoder #(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 2400000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        BIT_DATA,
  input  logic        BIT_READY,
  output logic [7:0]  BYTE_OUT,
  output logic        BYTE_VALID,
  output logic [15:0] BYTE_INDEX,
  output logic [15:0] FRAME_LEN,
  output logic        FRAME_START,
  output logic        FRAME_DONE,
  output logic        CRC_OK,
  output logic        FRAME_ERR
);

  localparam logic [1:0] S_HUNT    = 2'd0;
  localparam logic [1:0] S_LEN     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_CRC     = 2'd3;

  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);
  localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);

  // Reflected CRC32 (poly 0xEDB88320), one byte per call, fully unrolled.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  logic            prev_ready_q;
  logic [1:0]      state_q, state_d;
  logic [4:0]      zrun_q, zrun_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      byte_out_q, byte_out_d;
  logic            byte_valid_q, byte_valid_d;
  logic [15:0]     byte_index_q, byte_index_d;
  logic [15:0]     frame_len_q, frame_len_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            crc_ok_q, crc_ok_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      byte_sr_q, byte_sr_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [31:0]     crc_q, crc_d;
  logic [23:0]     rx_crc_q, rx_crc_d;

  logic        bit_evt;
  logic [7:0]  new_byte;
  logic [15:0] len_word;
  logic [16:0] pay_total;

  assign bit_evt   = BIT_READY & ~prev_ready_q;
  assign new_byte  = {byte_sr_q[6:0], BIT_DATA};
  assign len_word  = {new_byte, len_lo_q};
  // Odd-length payloads carry one trailing pad byte to fill the last word.
  assign pay_total = {1'b0, frame_len_q} + {16'd0, frame_len_q[0]};

  always_comb begin
    state_d       = state_q;
    zrun_d        = zrun_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_out_d    = byte_out_q;
    byte_index_d  = byte_index_q;
    frame_len_d   = frame_len_q;
    crc_ok_d      = crc_ok_q;
    byte_sr_d     = byte_sr_q;
    len_lo_d      = len_lo_q;
    crc_d         = crc_q;
    rx_crc_d      = rx_crc_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    to_cnt_d      = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);

    if (bit_evt) begin
      to_cnt_d = '0;
      zrun_d   = BIT_DATA ? 5'd0 : ((zrun_q == 5'd17) ? 5'd17 : zrun_q + 5'd1);
      if (state_q == S_HUNT) begin
        if (BIT_DATA && zrun_q == 5'd17) begin
          state_d    = S_LEN;
          bit_cnt_d  = 5'd0;
          byte_cnt_d = 16'd0;
        end
      end else if (bit_cnt_q == 5'd16) begin
        // Sync slot: the 17th bit of every word must be a 1.
        if (!BIT_DATA) begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
        end else begin
          bit_cnt_d = 5'd0;
        end
      end else begin
        byte_sr_d = new_byte;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd7 || bit_cnt_q == 5'd15) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          case (state_q)
            S_LEN: begin
              if (byte_cnt_q == 16'd0) begin
                len_lo_d = new_byte;
              end else if (len_word > MAX_LEN_W) begin
                frame_err_d = 1'b1;
                state_d     = S_HUNT;
              end else begin
                frame_len_d   = len_word;
                frame_start_d = 1'b1;
                crc_ok_d      = 1'b0;
                crc_d         = 32'hFFFFFFFF;
                byte_cnt_d    = 16'd0;
                state_d       = (len_word == 16'd0) ? S_CRC : S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              if (byte_cnt_q < frame_len_q) begin
                byte_out_d   = new_byte;
                byte_index_d = byte_cnt_q;
                byte_valid_d = 1'b1;
                crc_d        = crc32_byte(crc_q, new_byte);
              end
              if ({1'b0, byte_cnt_q} + 17'd1 == pay_total) begin
                byte_cnt_d = 16'd0;
                state_d    = S_CRC;
              end
            end
            default: begin
              case (byte_cnt_q[1:0])
                2'd0:    rx_crc_d[7:0]   = new_byte;
                2'd1:    rx_crc_d[15:8]  = new_byte;
                2'd2:    rx_crc_d[23:16] = new_byte;
                default: begin
                  crc_ok_d     = (~crc_q == {new_byte, rx_crc_q});
                  frame_done_d = 1'b1;
                  state_d      = S_HUNT;
                end
              endcase
            end
          endcase
        end
      end
    end else if (state_q != S_HUNT && to_cnt_d == TO_MAX) begin
      frame_err_d = 1'b1;
      state_d     = S_HUNT;
      zrun_d      = 5'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_ready_q  <= 1'b0;
      state_q       <= S_HUNT;
      zrun_q        <= 5'd0;
      bit_cnt_q     <= 5'd0;
      byte_cnt_q    <= 16'd0;
      to_cnt_q      <= '0;
      byte_out_q    <= 8'd0;
      byte_valid_q  <= 1'b0;
      byte_index_q  <= 16'd0;
      frame_len_q   <= 16'd0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      crc_ok_q      <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      prev_ready_q  <= BIT_READY;
      state_q       <= state_d;
      zrun_q        <= zrun_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      byte_index_q  <= byte_index_d;
      frame_len_q   <= frame_len_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      crc_ok_q      <= crc_ok_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Shift/CRC datapath is always rewritten before use, so it needs no reset.
  always_ff @(posedge CLK) begin
    byte_sr_q <= byte_sr_d;
    len_lo_q  <= len_lo_d;
    crc_q     <= crc_d;
    rx_crc_q  <= rx_crc_d;
  end

  assign BYTE_OUT    = byte_out_q;
  assign BYTE_VALID  = byte_valid_q;
  assign BYTE_INDEX  = byte_index_q;
  assign FRAME_LEN   = frame_len_q;
  assign FRAME_START = frame_start_q;
  assign FRAME_DONE  = frame_done_q;
  assign CRC_OK      = crc_ok_q;
  assign FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_ootx_frame_decoder.sv
// Bench for ootx_frame_decoder: frames are built at byte/word level with the expected
// strobe attached to the bit that completes it; a compare process checks every cycle.
module tb_ootx_frame_decoder;
  localparam int MAX_LEN = 64;
  localparam int TIMEOUT = 300;
  localparam int K_NONE = 0, K_START = 1, K_BYTE = 2, K_DONE = 3, K_ERR = 4;
  localparam int M_OK = 0, M_FLIP = 1, M_SYNC = 2, M_TRUNC = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        BIT_DATA = 1'b0;
  logic        BIT_READY = 1'b0;
  logic [7:0]  BYTE_OUT;
  logic        BYTE_VALID;
  logic [15:0] BYTE_INDEX;
  logic [15:0] FRAME_LEN;
  logic        FRAME_START;
  logic        FRAME_DONE;
  logic        CRC_OK;
  logic        FRAME_ERR;

  ootx_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .BIT_DATA(BIT_DATA), .BIT_READY(BIT_READY),
    .BYTE_OUT(BYTE_OUT), .BYTE_VALID(BYTE_VALID), .BYTE_INDEX(BYTE_INDEX),
    .FRAME_LEN(FRAME_LEN), .FRAME_START(FRAME_START), .FRAME_DONE(FRAME_DONE),
    .CRC_OK(CRC_OK), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic b; int kind; int val; int idx; } sbit_t;
  typedef struct { int cyc; int kind; int val; int idx; } exp_t;

  sbit_t      stim[$];
  exp_t       exp_q[$];
  exp_t       ce;
  logic [7:0] pay [0:255];
  int checks = 0, failures = 0, cyc = 0, byte_par = 0, last_cyc = 0;
  int m_len = 0, n_byte = 0, n_start = 0;
  logic chk_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, pay[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic add_bit(input logic b, input int kind, input int val, input int idx);
    sbit_t s;
    s.b = b; s.kind = kind; s.val = val; s.idx = idx;
    stim.push_back(s);
  endtask

  // One byte MSB first; every second byte closes the word with its sync bit.
  task automatic add_byte(input logic [7:0] v, input int kind, input int val, input int idx,
                          input logic sync);
    for (int i = 7; i >= 0; i--) add_bit(v[i], (i == 0) ? kind : K_NONE, val, idx);
    byte_par++;
    if (byte_par == 2) begin
      byte_par = 0;
      add_bit(sync, sync ? K_NONE : K_ERR, 0, 0);
    end
  endtask

  task automatic build(input int len, input int mode, input logic use_lit,
                       input logic [31:0] lit, input int trunc);
    logic [31:0] c;
    logic [7:0]  pad;
    int          ok;
    stim.delete();
    byte_par = 0;
    repeat ($urandom_range(0, 6)) add_bit(1'($urandom_range(0, 1)), K_NONE, 0, 0);
    repeat (17) add_bit(1'b0, K_NONE, 0, 0);
    add_bit(1'b1, K_NONE, 0, 0);
    add_byte(len[7:0], K_NONE, 0, 0, 1'b1);
    if (len > MAX_LEN) begin
      add_byte(len[15:8], K_ERR, 0, 0, 1'b1);
      return;
    end
    add_byte(len[15:8], K_START, len, 0, 1'b1);
    c  = use_lit ? lit : crc32(len);
    ok = 1;
    if (mode == M_FLIP && len > 0) begin
      pay[$urandom_range(0, len - 1)] ^= 8'(1 << $urandom_range(0, 7));
      ok = 0;
    end
    for (int i = 0; i < len; i++) begin
      add_byte(pay[i], K_BYTE, int'(pay[i]), i, !(mode == M_SYNC && i == 3));
      if (mode == M_SYNC && i == 3) return;
      if (mode == M_TRUNC && i == trunc) return;
    end
    pad = use_lit ? 8'h00 : 8'($urandom);
    if (len % 2 == 1) add_byte(pad, K_NONE, 0, 0, 1'b1);
    for (int k = 0; k < 4; k++) add_byte(c[8*k +: 8], (k == 3) ? K_DONE : K_NONE, ok, 0, 1'b1);
  endtask

  task automatic send(input int hold_last);
    for (int i = 0; i < stim.size(); i++) begin
      exp_t e;
      @(negedge CLK);
      BIT_DATA  = stim[i].b;
      BIT_READY = 1'b1;
      last_cyc  = cyc;
      if (stim[i].kind != K_NONE) begin
        e.cyc = cyc + 1; e.kind = stim[i].kind; e.val = stim[i].val; e.idx = stim[i].idx;
        exp_q.push_back(e);
      end
      repeat ((i == stim.size() - 1 && hold_last > 0) ? hold_last : int'($urandom_range(1, 2)))
        @(negedge CLK);
      BIT_READY = 1'b0;
      BIT_DATA  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 1)) @(negedge CLK);
    end
  endtask

  // Compare process: every cycle either the scheduled strobe or no strobe at all.
  always @(negedge CLK) begin
    if (!RST_N) begin
      m_len = 0;
    end else if (chk_en) begin
      if (BYTE_VALID) n_byte++;
      if (FRAME_START) n_start++;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_event kind=%0d due=%0d now=%0d", exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ce = exp_q.pop_front();
        case (ce.kind)
          K_START: begin
            chk("start_strobes", 32'({FRAME_START, BYTE_VALID, FRAME_DONE, FRAME_ERR}), 32'h8);
            chk("frame_len", 32'(FRAME_LEN), 32'(ce.val));
            m_len = ce.val;
          end
          K_BYTE: begin
            chk("byte_strobes", 32'({FRAME_START, BYTE_VALID, FRAME_DONE, FRAME_ERR}), 32'h4);
            chk("byte_out", 32'(BYTE_OUT), 32'(ce.val));
            chk("byte_index", 32'(BYTE_INDEX), 32'(ce.idx));
          end
          K_DONE: begin
            chk("done_strobes", 32'({FRAME_START, BYTE_VALID, FRAME_DONE, FRAME_ERR}), 32'h2);
            chk("crc_ok", 32'(CRC_OK), 32'(ce.val));
          end
          default: chk("err_strobes", 32'({FRAME_START, BYTE_VALID, FRAME_DONE, FRAME_ERR}), 32'h1);
        endcase
      end else begin
        chk("idle_strobes", 32'({FRAME_START, BYTE_VALID, FRAME_DONE, FRAME_ERR}), 32'h0);
        chk("frame_len_hold", 32'(FRAME_LEN), 32'(m_len));
      end
    end
  end

  initial begin
    int nb0, ns0, len, r, mode;
    repeat (3) @(negedge CLK);
    chk("rst_byte_out", 32'(BYTE_OUT), 32'h0);
    chk("rst_byte_index", 32'(BYTE_INDEX), 32'h0);
    chk("rst_frame_len", 32'(FRAME_LEN), 32'h0);
    chk("rst_strobes", 32'({FRAME_START, BYTE_VALID, FRAME_DONE, FRAME_ERR}), 32'h0);
    chk("rst_crc_ok", 32'(CRC_OK), 32'h0);
    RST_N  = 1'b1;
    chk_en = 1'b1;

    // Test-plan frame "123456789" with the literal CRC bytes 26 39 F4 CB.
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    chk("crc32_check_value", crc32(9), 32'hCBF43926);
    nb0 = n_byte;
    build(9, M_OK, 1'b1, 32'hCBF43926, 0);
    send(0);
    repeat (4) @(negedge CLK);
    chk("tp1_byte_count", 32'(n_byte - nb0), 32'd9);
    chk("tp1_frame_len", 32'(FRAME_LEN), 32'd9);
    chk("tp1_crc_ok_held", 32'(CRC_OK), 32'd1);

    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    build(9, M_FLIP, 1'b1, 32'hCBF43926, 0);
    send(0);
    repeat (4) @(negedge CLK);
    chk("tp2_crc_bad_held", 32'(CRC_OK), 32'd0);

    nb0 = n_byte;
    build(0, M_OK, 1'b1, 32'h00000000, 0);
    send(0);
    repeat (4) @(negedge CLK);
    chk("zero_len_bytes", 32'(n_byte - nb0), 32'd0);
    chk("zero_len_crc_ok", 32'(CRC_OK), 32'd1);

    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    build(8, M_SYNC, 1'b0, 32'h0, 0);
    send(0);
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    build(8, M_OK, 1'b0, 32'h0, 0);
    send(0);
    repeat (4) @(negedge CLK);
    chk("after_sync_err_crc_ok", 32'(CRC_OK), 32'd1);

    ns0 = n_start;
    build(MAX_LEN + 1, M_OK, 1'b0, 32'h0, 0);
    send(0);
    repeat (4) @(negedge CLK);
    chk("too_long_no_start", 32'(n_start - ns0), 32'd0);

    for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'($urandom);
    build(MAX_LEN, M_OK, 1'b0, 32'h0, 0);
    send(0);

    // Stall mid-payload with the last bit held high for 10 cycles.
    for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
    build(10, M_TRUNC, 1'b0, 32'h0, 3);
    send(10);
    ce.cyc = last_cyc + 1 + TIMEOUT; ce.kind = K_ERR; ce.val = 0; ce.idx = 0;
    exp_q.push_back(ce);
    repeat (TIMEOUT + 20) @(negedge CLK);

    // Reset in the middle of a frame: discarded silently.
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    build(6, M_TRUNC, 1'b0, 32'h0, 2);
    send(0);
    @(posedge CLK); #2 RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst_frame_len", 32'(FRAME_LEN), 32'h0);
    chk("midrst_byte_out", 32'(BYTE_OUT), 32'h0);
    chk("midrst_strobes", 32'({FRAME_START, BYTE_VALID, FRAME_DONE, FRAME_ERR}), 32'h0);
    @(posedge CLK); #2 RST_N = 1'b1;
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    build(5, M_OK, 1'b0, 32'h0, 0);
    send(0);

    for (int f = 0; f < 10; f++) begin
      r    = int'($urandom_range(0, 9));
      len  = int'($urandom_range(0, 40));
      mode = (r >= 6 && r <= 7) ? M_FLIP : M_OK;
      if (r == 8 && len >= 4) mode = M_SYNC;
      if (r == 9) len = int'($urandom_range(MAX_LEN + 1, 200));
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      build(len, mode, 1'b0, 32'h0, 0);
      send(0);
    end

    repeat (10) @(negedge CLK);
    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
